// File: rtl/img_pkg.sv
// Shared image geometry, FSM state encoding and the pixel-stream payload
// used by the frame read path.
package img_pkg;

  localparam int unsigned HIEGHT = 30;
  localparam int unsigned WIDTH  = 30;
  localparam int unsigned BPP    = 3;

  localparam int unsigned PIXELS = HIEGHT * WIDTH;
  localparam int unsigned ADDR_W = $clog2(PIXELS);
  localparam int unsigned PIX_W  = 8 * BPP;
  localparam int unsigned COL_W  = $clog2(WIDTH);
  localparam int unsigned ROW_W  = $clog2(HIEGHT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // One stream beat: markers travel beside the pixel.
  typedef struct packed {
    logic             eof;
    logic             eol;
    logic             sof;
    logic [PIX_W-1:0] data;
  } pix_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO that absorbs returning memory reads while the downstream
// stalls. Head entry drives the stream outputs directly from storage.
// Ports:
//   clk, rst  - clock, async active-high reset (empties FIFO, zeroes storage)
//   push, din - write one beat
//   pop       - remove head beat (ignored when empty)
//   dout      - head beat
//   count     - occupancy 0..2, used for read credit
module pix_skid_fifo
  import img_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  pix_t       din,
  input  logic       pop,
  output pix_t       dout,
  output logic [1:0] count
);

  pix_t slot0_q;
  pix_t slot1_q;
  logic wr_ptr_q;
  logic rd_ptr_q;
  logic do_pop_c;

  assign do_pop_c = pop && (count != 2'd0);
  assign dout     = rd_ptr_q ? slot1_q : slot0_q;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) slot1_q <= din;
        else          slot0_q <= din;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop_c) rd_ptr_q <= ~rd_ptr_q;
      count <= count + 2'(push) - 2'(do_pop_c);
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Read side of the frame memory: once a frame is loaded, sweeps the memory in
// raster order and presents it as a valid/ready pixel stream with sof/eol/eof.
// Ports:
//   clk, rst     - clock, async active-high reset
//   start        - one-cycle request to stream a frame (ignored while busy)
//   mem_done     - memory reports a loaded frame (sampled in ARMED only)
//   mem_rd_en    - read strobe, mem_rd_addr - next address to issue
//   mem_rd_data  - read data, valid one cycle after the issuing edge
//   m_valid/m_ready/m_data/m_sof/m_eol/m_eof - output pixel stream
//   busy         - frame in progress, frame_done - one-cycle end pulse
module frame_reader
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done
);

  state_e           state_q;
  state_e           state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             inflight_q;
  logic             pend_sof_q;
  logic             pend_eol_q;
  logic             pend_eof_q;

  logic [1:0]       fifo_count;
  pix_t             fifo_in;
  pix_t             fifo_out;
  logic             xfer_c;
  logic [1:0]       occ_c;
  logic             credit_c;
  logic             last_addr_c;
  logic             last_col_c;

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_out.data;
  assign m_sof   = fifo_out.sof;
  assign m_eol   = fifo_out.eol;
  assign m_eof   = fifo_out.eof;
  assign xfer_c  = m_valid && m_ready;

  // Slots committed after this edge; the beat leaving now frees its slot,
  // which is what lets a steady stream sustain one pixel per cycle.
  assign occ_c       = 2'(inflight_q) + fifo_count - 2'(xfer_c);
  assign credit_c    = (occ_c < 2'd2);
  assign last_addr_c = (mem_rd_addr == ADDR_W'(PIXELS - 1));
  assign last_col_c  = (col_q == COL_W'(WIDTH - 1));

  assign fifo_in.eof  = pend_eof_q;
  assign fifo_in.eol  = pend_eol_q;
  assign fifo_in.sof  = pend_sof_q;
  assign fifo_in.data = mem_rd_data;

  pix_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (fifo_in),
    .pop   (xfer_c),
    .dout  (fifo_out),
    .count (fifo_count)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, read strobe and status
  always_comb begin
    state_d    = state_q;
    mem_rd_en  = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = ARMED;
      ARMED: if (mem_done) state_d = READ;
      READ: begin
        mem_rd_en = credit_c;
        if (credit_c && last_addr_c) state_d = DRAIN;
      end
      DRAIN: if (xfer_c && fifo_out.eof) state_d = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address / raster counters and the one-deep in-flight marker stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_addr <= '0;
      col_q       <= '0;
      row_q       <= '0;
      inflight_q  <= 1'b0;
      pend_sof_q  <= 1'b0;
      pend_eol_q  <= 1'b0;
      pend_eof_q  <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (mem_rd_en) begin
        pend_sof_q  <= (mem_rd_addr == '0);
        pend_eol_q  <= last_col_c;
        pend_eof_q  <= last_addr_c;
        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
        if (last_col_c) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end else if (state_q == DONE) begin
        mem_rd_addr <= '0;
        col_q       <= '0;
        row_q       <= '0;
      end
    end
  end

endmodule
